// File: rtl/addsub_pkg.sv
// Shared constants for the serial add/sub responder: mode encoding, FSM states, default width.
package addsub_pkg;

    localparam int   WIDTH_DEFAULT = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder; the serial datapath reuses one instance every cycle.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_serial_resp.sv
// Bit-serial WIDTH-bit adder/subtractor with valid/ready request and response channels.
// Optional macro ADDSUB_SERIAL_OVF_EN enables the signed-overflow output (otherwise ovf is 0).
module addsub_serial_resp
    import addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    // Operands shift right each CALC cycle, so the adder always sees bit 0.
    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (bx_q[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last      = (cnt == CW'(WIDTH - 1));
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);

`ifndef ADDSUB_SERIAL_OVF_EN
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_q   <= '0;
            bx_q  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            cout  <= 1'b0;
`ifdef ADDSUB_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Subtract as A + ~B + 1: invert B here, seed carry with mode.
                        a_q   <= a;
                        bx_q  <= b ^ {WIDTH{mode}};
                        carry <= mode;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    out   <= {fa_s, out[WIDTH-1:1]};
                    a_q   <= a_q >> 1;
                    bx_q  <= bx_q >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout  <= fa_c;
`ifdef ADDSUB_SERIAL_OVF_EN
                        ovf   <= carry ^ fa_c;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial_resp.sv
// Randomized self-checking bench for addsub_serial_resp against an arithmetic reference model.
module tb_addsub_serial_resp;
    import addsub_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         req_ready;
    logic         rsp_valid;
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    addsub_serial_resp #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .out       (out),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, out} from integer arithmetic on unsigned and signed views.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic m);
        int xi, yi, sx, sy, u, r;
        logic co, ov;
        logic [W-1:0] o;
        xi = int'(x);
        yi = int'(y);
        u  = m ? xi - yi : xi + yi;
        co = m ? (xi >= yi) : (u >= (1 << W));
        o  = W'((u + (1 << W)) % (1 << W));
        sx = (xi >= (1 << (W-1))) ? xi - (1 << W) : xi;
        sy = (yi >= (1 << (W-1))) ? yi - (1 << W) : yi;
        r  = m ? sx - sy : sx + sy;
        ov = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
`ifndef ADDSUB_SERIAL_OVF_EN
        ov = 1'b0;
`endif
        return {ov, co, o};
    endfunction

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im,
                          input int hold);
        logic [W+1:0] e;
        int n;
        e = model(ia, ib, im);
        @(negedge clk);
        chk("idle_rdy", req_ready, 1);
        a = ia; b = ib; mode = im; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        // Operands are scrambled after acceptance; the result must not change.
        a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("busy_rdy", req_ready, 0);
            @(negedge clk);
            n++;
        end
        chk("latency", n, W);
        chk("out", out, e[W-1:0]);
        chk("cout", cout, e[W]);
        chk("ovf", ovf, e[W+1]);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_vld", rsp_valid, 1);
            chk("hold_out", out, e[W-1:0]);
            chk("hold_cout", cout, e[W]);
            chk("hold_rdy", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rel_vld", rsp_valid, 0);
        chk("rel_rdy", req_ready, 1);
        chk("keep_out", out, e[W-1:0]);
        chk("keep_cout", cout, e[W]);
    endtask

    task automatic reset_mid(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im,
                             input int wait_n);
        @(negedge clk);
        a = ia; b = ib; mode = im; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (wait_n) @(negedge clk);
        if (wait_n >= W) chk("pre_rst_vld", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_out", out, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_vld", rsp_valid, 0);
        chk("rst_rdy", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] qa [2];
        logic [W-1:0] qb [2];
        logic         qm [2];
        logic [W+1:0] eq [$];
        logic [W+1:0] e;
        int idx, got, acc0, acc1;
        bit adv;

        #2 rst_n = 1'b0;
        #1;
        chk("init_out", out, 0);
        chk("init_cout", cout, 0);
        chk("init_ovf", ovf, 0);
        chk("init_vld", rsp_valid, 0);
        chk("init_rdy", req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0011, 4'b1000, MODE_SUB, 0);
        reset_mid(4'b1000, 4'b1000, MODE_ADD, 2);
        run_op(4'b0111, 4'b0001, MODE_ADD, 0);
        run_op(4'b1000, 4'b1000, MODE_ADD, 0);
        run_op(4'b0011, 4'b0010, MODE_ADD, 5);
        reset_mid(4'b1000, 4'b1000, MODE_ADD, W);

        // Back-to-back with both valid and ready held high.
        qa[0] = 4'b0101; qb[0] = 4'b0011; qm[0] = MODE_SUB;
        qa[1] = 4'b1111; qb[1] = 4'b0001; qm[1] = MODE_ADD;
        idx = 0; got = 0; acc0 = -100; acc1 = 0; adv = 1'b0;
        @(negedge clk);
        a = qa[0]; b = qb[0]; mode = qm[0]; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int n = 0; n < 40 && got < 2; n++) begin
            if (adv) begin
                adv = 1'b0;
                if (idx < 2) begin
                    a = qa[idx]; b = qb[idx]; mode = qm[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rsp_valid && eq.size() > 0) begin
                e = eq.pop_front();
                chk("b2b_out", out, e[W-1:0]);
                chk("b2b_cout", cout, e[W]);
                chk("b2b_ovf", ovf, e[W+1]);
                got++;
            end
            if (req_ready && req_valid && idx < 2) begin
                if (idx == 0) acc0 = n; else acc1 = n;
                eq.push_back(model(qa[idx], qb[idx], qm[idx]));
                idx++;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("b2b_cnt", got, 2);
        chk("b2b_gap", acc1 - acc0, W + 2);

        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
